mem_access_seq: RTL

- Multi-cycle sequencer between the single-cycle datapath and a byte-wide data memory.
- Takes the decoder's memory controls (MemRead, MemWrite, MemNum, UnSigned) with the ALU address and rt data.
- Breaks each byte, halfword or word access into 1/2/4 big-endian byte transfers and stalls the PC while they run.
- Returns the sign- or zero-extended load result and flags misaligned or out-of-range accesses as halt conditions.

---
 rtl/mem_access_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// Sequences byte/half/word loads and stores over a byte-wide data memory,
// stalling the datapath until the big-endian transfers complete.
module mem_access_seq #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_num_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        range_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, FINISH, ERROR} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        uns_q, uns_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        rng_q, rng_d;

    logic        valid_req;
    logic [1:0]  req_last;
    logic [32:0] req_end;
    logic        req_mis;
    logic        req_rng;
    logic [31:0] assembled;
    logic [31:0] extended;
    logic [1:0]  byte_sel;

    // last_q holds N-1 so the final transfer is simply cnt_q == last_q
    always_comb begin
        valid_req = start_i && (mem_read_i ^ mem_write_i) && (mem_num_i != 2'b00);
        case (mem_num_i)
            2'b01:   req_last = 2'd0;
            2'b10:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        req_end   = {1'b0, addr_i} + {31'b0, req_last} + 33'd1;
        req_mis   = ((mem_num_i == 2'b10) && addr_i[0]) ||
                    ((mem_num_i == 2'b11) && (addr_i[1:0] != 2'b00));
        req_rng   = req_end > 33'(MEM_BYTES);
        assembled = {asm_q, mem_rdata_i};
        case (last_q)
            2'd0:    extended = uns_q ? {24'b0, assembled[7:0]}
                                      : {{24{assembled[7]}}, assembled[7:0]};
            2'd1:    extended = uns_q ? {16'b0, assembled[15:0]}
                                      : {{16{assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
        byte_sel = last_q - cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            asm_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        uns_d   = uns_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        rng_d   = rng_q;
        case (state_q)
            IDLE: begin
                if (valid_req) begin
                    if (req_mis || req_rng) begin
                        mis_d   = mis_q | req_mis;
                        rng_d   = rng_q | req_rng;
                        state_d = ERROR;
                    end else begin
                        base_d  = addr_i;
                        wdata_d = wdata_i;
                        last_d  = req_last;
                        write_d = mem_write_i;
                        uns_d   = unsigned_i;
                        cnt_d   = 2'd0;
                        asm_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    if (!write_q) asm_d = assembled[23:0];
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        if (!write_q) rdata_d = extended;
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = ERROR;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        done_o      = 1'b0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE:   stall_o = valid_req;
            ACCESS: begin
                stall_o    = 1'b1;
                mem_re_o   = !write_q;
                mem_we_o   = write_q;
                mem_addr_o = base_q + {30'b0, cnt_q};
                case (byte_sel)
                    2'd0:    mem_wdata_o = wdata_q[7:0];
                    2'd1:    mem_wdata_o = wdata_q[15:8];
                    2'd2:    mem_wdata_o = wdata_q[23:16];
                    default: mem_wdata_o = wdata_q[31:24];
                endcase
            end
            FINISH:  done_o  = 1'b1;
            default: stall_o = 1'b1;
        endcase
    end

    assign rdata_o    = rdata_q;
    assign misalign_o = mis_q;
    assign range_o    = rng_q;
endmodule
